// File: rtl/operand_fetch_seq.sv
// Operand sequencer for the 16-bit FU: resolves MSP430 source/destination addressing, fetches
// extension words and operands over req/ack, and writes the result back. Constant generator: CONST_GEN_EN.
module operand_fetch_seq #(
  parameter logic [3:0] PC_REG = 4'd0,
  parameter logic [3:0] SP_REG = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        two_op,
  input  logic [1:0]  as_mode,
  input  logic        ad_mode,
  input  logic [3:0]  src_reg,
  input  logic [3:0]  dst_reg,
  input  logic        bw,
  input  logic        no_wb,
  output logic        busy,
  output logic        done,
  output logic [3:0]  rf_a_sel,
  input  logic [15:0] rf_a_data,
  output logic [3:0]  rf_b_sel,
  input  logic [15:0] rf_b_data,
  input  logic [15:0] pc,
  output logic        pc_inc,
  output logic        rf_we,
  output logic [3:0]  rf_wsel,
  output logic [15:0] rf_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_bw,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] fu_src,
  output logic [15:0] fu_dst,
  input  logic [15:0] fu_result,
  output logic        sr_we
);

  typedef enum logic [2:0] {
    IDLE, S_EXT, S_MEM, D_EXT, D_MEM, EXEC, WB_MEM, DONE
  } state_t;

  state_t state_q, state_d;

  logic        two_op_q, ad_q, bw_q, no_wb_q;
  logic [1:0]  as_q;
  logic [3:0]  src_sel_q, dst_sel_q;
  logic        smem_q, sreg_q, imm_q, abs_q;
  logic [15:0] ext_q, sop_q, dop_q, daddr_q, res_q;

  logic        in_cg, in_abs, in_imm, in_sext, in_smem;
  logic [15:0] cg_val;

`ifdef CONST_GEN_EN
  // R3 in any mode and R2 in the two indirect modes never touch the bus
  assign in_cg  = (src_reg == 4'd3) || (src_reg == 4'd2 && as_mode[1]);
  assign in_abs = (src_reg == 4'd2) && (as_mode == 2'b01);
  always_comb begin
    cg_val = 16'h0000;
    if (src_reg == 4'd3) begin
      case (as_mode)
        2'b00:   cg_val = 16'h0000;
        2'b01:   cg_val = 16'h0001;
        2'b10:   cg_val = 16'h0002;
        default: cg_val = 16'hFFFF;
      endcase
    end else if (src_reg == 4'd2) begin
      cg_val = as_mode[0] ? 16'h0008 : 16'h0004;
    end
  end
`else
  assign in_cg  = 1'b0;
  assign in_abs = 1'b0;
  assign cg_val = 16'h0000;
`endif

  assign in_imm  = (as_mode == 2'b11) && (src_reg == PC_REG) && !in_cg;
  assign in_sext = ((as_mode == 2'b01) && !in_cg) || in_imm;
  assign in_smem = (as_mode != 2'b00) && !in_imm && !in_cg;

  logic        dpath, res_reg, res_mem;
  logic [15:0] src_addr, dst_addr, rd_val, wb_val, inc_step;

  assign dpath    = two_op_q & ad_q;
  assign res_reg  = two_op_q ? !ad_q : sreg_q;
  assign res_mem  = two_op_q ? ad_q : smem_q;
  assign src_addr = (as_q == 2'b01) ? ((abs_q ? 16'h0000 : rf_a_data) + ext_q) : rf_a_data;
  assign dst_addr = rf_b_data + ext_q;
  assign rd_val   = bw_q ? {8'h00, mem_rdata[7:0]} : mem_rdata;
  assign wb_val   = bw_q ? {8'h00, fu_result[7:0]} : fu_result;
  assign inc_step = (bw_q && src_sel_q != PC_REG && src_sel_q != SP_REG) ? 16'd1 : 16'd2;

  assign rf_a_sel = src_sel_q;
  assign rf_b_sel = dst_sel_q;

  // Register operands are read live in EXEC and held in the latches for DONE,
  // so an EXEC write to the same register cannot disturb the FU inputs.
  assign fu_src = (state_q == EXEC && sreg_q) ? rf_a_data : sop_q;
  assign fu_dst = !two_op_q ? fu_src :
                  (state_q == EXEC && !ad_q) ? rf_b_data : dop_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    pc_inc    = 1'b0;
    rf_we     = 1'b0;
    rf_wsel   = 4'd0;
    rf_wdata  = 16'h0000;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_bw    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    sr_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (in_sext)                 state_d = S_EXT;
          else if (in_smem)            state_d = S_MEM;
          else if (two_op && ad_mode)  state_d = D_EXT;
          else                         state_d = EXEC;
        end
      end
      S_EXT: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) begin
          pc_inc  = 1'b1;
          state_d = smem_q ? S_MEM : (dpath ? D_EXT : EXEC);
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_bw   = bw_q;
        mem_addr = src_addr;
        if (mem_ack) begin
          if (as_q == 2'b11) begin
            rf_we    = 1'b1;
            rf_wsel  = src_sel_q;
            rf_wdata = rf_a_data + inc_step;
          end
          state_d = dpath ? D_EXT : EXEC;
        end
      end
      D_EXT: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) begin
          pc_inc  = 1'b1;
          state_d = D_MEM;
        end
      end
      D_MEM: begin
        mem_req  = 1'b1;
        mem_bw   = bw_q;
        mem_addr = dst_addr;
        if (mem_ack) state_d = EXEC;
      end
      EXEC: begin
        sr_we = 1'b1;
        if (res_reg && !no_wb_q) begin
          rf_we    = 1'b1;
          rf_wsel  = two_op_q ? dst_sel_q : src_sel_q;
          rf_wdata = wb_val;
        end
        state_d = (res_mem && !no_wb_q) ? WB_MEM : DONE;
      end
      WB_MEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_bw    = bw_q;
        mem_addr  = daddr_q;
        mem_wdata = res_q;
        if (mem_ack) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      two_op_q  <= 1'b0;
      ad_q      <= 1'b0;
      bw_q      <= 1'b0;
      no_wb_q   <= 1'b0;
      as_q      <= 2'b00;
      src_sel_q <= 4'd0;
      dst_sel_q <= 4'd0;
      smem_q    <= 1'b0;
      sreg_q    <= 1'b0;
      imm_q     <= 1'b0;
      abs_q     <= 1'b0;
      ext_q     <= 16'h0000;
      sop_q     <= 16'h0000;
      dop_q     <= 16'h0000;
      daddr_q   <= 16'h0000;
      res_q     <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          two_op_q  <= two_op;
          ad_q      <= ad_mode;
          bw_q      <= bw;
          no_wb_q   <= no_wb;
          as_q      <= as_mode;
          src_sel_q <= src_reg;
          dst_sel_q <= dst_reg;
          smem_q    <= in_smem;
          sreg_q    <= (as_mode == 2'b00) && !in_cg;
          imm_q     <= in_imm;
          abs_q     <= in_abs;
          sop_q     <= cg_val;
        end
        S_EXT: if (mem_ack) begin
          ext_q <= mem_rdata;
          if (imm_q) sop_q <= rd_val;
        end
        S_MEM: if (mem_ack) begin
          sop_q <= rd_val;
          // single-operand results go back where the operand came from
          if (!two_op_q) daddr_q <= src_addr;
        end
        D_EXT: if (mem_ack) ext_q <= mem_rdata;
        D_MEM: if (mem_ack) begin
          dop_q   <= rd_val;
          daddr_q <= dst_addr;
        end
        EXEC: begin
          sop_q <= fu_src;
          dop_q <= fu_dst;
          res_q <= wb_val;
        end
        default: ;
      endcase
    end
  end

endmodule
